instr_encoder: RTL and testbench



---
 rtl/instr_enc_pkg.sv | 50 +++++
 rtl/rv_imm_packer.sv | 58 +++++
 rtl/instr_encoder.sv | 191 +++++++++++++++++++
 tb/tb_instr_encoder.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_enc_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
// Holds request kinds, immediate formats, FSM states, opcodes and funct7 values.
package instr_enc_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [3:0] {
    KIND_R      = 4'd0,
    KIND_IARITH = 4'd1,
    KIND_LOAD   = 4'd2,
    KIND_STORE  = 4'd3,
    KIND_BRANCH = 4'd4,
    KIND_JAL    = 4'd5,
    KIND_JALR   = 4'd6,
    KIND_LUI    = 4'd7,
    KIND_AUIPC  = 4'd8,
    KIND_LI     = 4'd9
  } instr_kind_t;

  // FMT_NONE carries no immediate bits (R-type, LI, illegal kinds).
  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_SHAMT = 3'd2,
    FMT_S     = 3'd3,
    FMT_B     = 3'd4,
    FMT_U     = 3'd5,
    FMT_J     = 3'd6
  } imm_fmt_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_EMIT2 = 1'b1
  } enc_state_t;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IARITH = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

endpackage

// File: rtl/rv_imm_packer.sv
// Combinational immediate packer: places req_imm into the I/S/B/U/J bit fields.
// With INSTR_ENC_IMM_CHECK_EN defined, imm_ok flags immediates the format cannot hold.
module rv_imm_packer
  import instr_enc_pkg::*;
(
  input  imm_fmt_t          fmt,
  input  logic [XLEN-1:0]   imm,
  input  logic              alt,
  output logic [XLEN-1:0]   field,
  output logic              imm_ok
);

  always_comb begin
    field = '0;
    case (fmt)
      FMT_I: field[31:20] = imm[11:0];
      FMT_SHAMT: begin
        field[30]    = alt;
        field[24:20] = imm[4:0];
      end
      FMT_S: begin
        field[31:25] = imm[11:5];
        field[11:7]  = imm[4:0];
      end
      FMT_B: begin
        field[31]    = imm[12];
        field[30:25] = imm[10:5];
        field[11:8]  = imm[4:1];
        field[7]     = imm[11];
      end
      FMT_U: field[31:12] = imm[31:12];
      FMT_J: begin
        field[31]    = imm[20];
        field[30:21] = imm[10:1];
        field[20]    = imm[11];
        field[19:12] = imm[19:12];
      end
      default: field = '0;
    endcase
  end

`ifdef INSTR_ENC_IMM_CHECK_EN
  // A signed value fits in N bits exactly when bits [31:N-1] are all equal.
  always_comb begin
    imm_ok = 1'b1;
    case (fmt)
      FMT_I, FMT_SHAMT, FMT_S: imm_ok = (imm[31:11] == {21{imm[11]}});
      FMT_B:                   imm_ok = (imm[31:12] == {20{imm[12]}}) && !imm[0];
      FMT_J:                   imm_ok = (imm[31:20] == {12{imm[20]}}) && !imm[0];
      FMT_U:                   imm_ok = (imm[11:0] == 12'd0);
      default:                 imm_ok = 1'b1;
    endcase
  end
`else
  assign imm_ok = 1'b1;
`endif

endmodule

// File: rtl/instr_encoder.sv
// RV32I field-level request to instruction-word encoder with LI expansion.
// Optional immediate range rejection is enabled by defining INSTR_ENC_IMM_CHECK_EN.
module instr_encoder
  import instr_enc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_kind,
  input  logic [2:0]        req_funct3,
  input  logic              req_alt,
  input  logic [REG_AW-1:0] req_rd,
  input  logic [REG_AW-1:0] req_rs1,
  input  logic [REG_AW-1:0] req_rs2,
  input  logic [XLEN-1:0]   req_imm,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [XLEN-1:0]   instr,
  output logic              instr_last,
  output logic              err,
  output enc_state_t        dbg_state
);

  // Handshakes: a beat moves on a rising edge where valid && ready; the
  // producer holds valid and payload stable until then, and ready may not
  // depend combinationally on the same-side valid.
  enc_state_t state, next_state;

  imm_fmt_t        fmt;
  logic [6:0]      opcode;
  logic [6:0]      funct7;
  logic            use_rd, use_rs1, use_rs2, use_f3, legal;
  logic [XLEN-1:0] imm_field;
  logic            imm_ok;
  logic [XLEN-1:0] base_word;

  logic            is_li, li_small, li_zero_lo, two_word;
  logic [11:0]     li_lo;
  logic [19:0]     li_hi;
  logic [XLEN-1:0] li_addi_x0, li_lui, li_addi_rd;

  logic [XLEN-1:0] first_word;
  logic [XLEN-1:0] second_q;
  logic            accept, reject, take;

  always_comb begin
    fmt     = FMT_NONE;
    opcode  = OPC_R;
    funct7  = FUNCT7_BASE;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_f3  = 1'b0;
    legal   = 1'b1;
    case (req_kind)
      KIND_R: begin
        opcode  = OPC_R;
        funct7  = req_alt ? FUNCT7_ALT : FUNCT7_BASE;
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_f3  = 1'b1;
      end
      KIND_IARITH: begin
        opcode  = OPC_IARITH;
        fmt     = (req_funct3 == 3'b001 || req_funct3 == 3'b101) ? FMT_SHAMT : FMT_I;
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_f3  = 1'b1;
      end
      KIND_LOAD: begin
        opcode  = OPC_LOAD;
        fmt     = FMT_I;
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_f3  = 1'b1;
      end
      KIND_STORE: begin
        opcode  = OPC_STORE;
        fmt     = FMT_S;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_f3  = 1'b1;
      end
      KIND_BRANCH: begin
        opcode  = OPC_BRANCH;
        fmt     = FMT_B;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_f3  = 1'b1;
      end
      KIND_JAL: begin
        opcode  = OPC_JAL;
        fmt     = FMT_J;
        use_rd  = 1'b1;
      end
      KIND_JALR: begin
        opcode  = OPC_JALR;
        fmt     = FMT_I;
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_f3  = 1'b1;
      end
      KIND_LUI: begin
        opcode  = OPC_LUI;
        fmt     = FMT_U;
        use_rd  = 1'b1;
      end
      KIND_AUIPC: begin
        opcode  = OPC_AUIPC;
        fmt     = FMT_U;
        use_rd  = 1'b1;
      end
      KIND_LI: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  rv_imm_packer u_imm_packer (
    .fmt    (fmt),
    .imm    (req_imm),
    .alt    (req_alt),
    .field  (imm_field),
    .imm_ok (imm_ok)
  );

  assign base_word = {funct7,
                      use_rs2 ? req_rs2    : 5'd0,
                      use_rs1 ? req_rs1    : 5'd0,
                      use_f3  ? req_funct3 : 3'd0,
                      use_rd  ? req_rd     : 5'd0,
                      opcode} | imm_field;

  // hi is rounded so that hi<<12 plus the sign-extended lo rebuilds req_imm.
  assign is_li      = (req_kind == KIND_LI);
  assign li_lo      = req_imm[11:0];
  assign li_hi      = req_imm[31:12] + {19'd0, req_imm[11]};
  assign li_small   = (req_imm[31:11] == {21{req_imm[11]}});
  assign li_zero_lo = (req_imm[11:0] == 12'd0);
  assign li_addi_x0 = {li_lo, 5'd0, 3'b000, req_rd, OPC_IARITH};
  assign li_lui     = {li_hi, req_rd, OPC_LUI};
  assign li_addi_rd = {li_lo, req_rd, 3'b000, req_rd, OPC_IARITH};

  assign first_word = is_li ? (li_small ? li_addi_x0 : li_lui) : base_word;
  assign two_word   = is_li && !li_small && !li_zero_lo;

  assign req_ready = (state == ST_IDLE) && (!instr_valid || instr_ready);
  assign accept    = req_valid && req_ready;
  assign reject    = !legal || !imm_ok;
  assign take      = instr_valid && instr_ready;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (accept && !reject && two_word) next_state = ST_EMIT2;
      ST_EMIT2: if (take) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_last  <= 1'b0;
      err         <= 1'b0;
      second_q    <= '0;
    end else begin
      err <= accept && reject;
      if (accept && !reject) begin
        instr_valid <= 1'b1;
        instr       <= first_word;
        instr_last  <= !two_word;
        if (two_word) second_q <= li_addi_rd;
      end else if (state == ST_EMIT2 && take) begin
        instr      <= second_q;
        instr_last <= 1'b1;
      end else if (take) begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vector table, hand sequences
// for stalls/errors/reset, and randomized requests against a field-arithmetic model.
module tb_instr_encoder;
  import instr_enc_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [3:0]  req_kind;
  logic [2:0]  req_funct3;
  logic        req_alt;
  logic [4:0]  req_rd, req_rs1, req_rs2;
  logic [31:0] req_imm;
  logic        instr_valid, instr_ready;
  logic [31:0] instr;
  logic        instr_last, err;
  enc_state_t  dbg_state;

  instr_encoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_kind    (req_kind),
    .req_funct3  (req_funct3),
    .req_alt     (req_alt),
    .req_rd      (req_rd),
    .req_rs1     (req_rs1),
    .req_rs2     (req_rs2),
    .req_imm     (req_imm),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_last  (instr_last),
    .err         (err),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [32:0] exp_q[$];
  int          exp_err  = 0;
  int          seen_err = 0;
  bit          rand_ready = 0;

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%09h required 0x%09h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [6:0] opc_of(input int k);
    case (k)
      0: return 7'h33;
      1: return 7'h13;
      2: return 7'h03;
      3: return 7'h23;
      4: return 7'h63;
      5: return 7'h6F;
      6: return 7'h67;
      7: return 7'h37;
      8: return 7'h17;
      default: return 7'h00;
    endcase
  endfunction

  task automatic model_req(input logic [3:0] kind, input logic [2:0] f3, input logic alt,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] imm);
    int k, d, a, b, f, s;
    logic [31:0] u, w, hi, sev;
    logic [6:0] opc;
    bit bad;
    k = kind; d = rd; a = rs1; b = rs2; f = f3; s = imm; u = imm;
    opc = opc_of(k);
    bad = 0;
    w = 0;
    sev = alt ? 32'h40000000 : 32'h0;
    if (k > 9) begin
      exp_err++;
      return;
    end
    if (k == 9) begin
      if (s >= -2048 && s <= 2047) begin
        exp_q.push_back({1'b1, (u % 4096) * 1048576 + d * 128 + 32'h13});
      end else begin
        hi = (u + 32'h800) / 4096;
        if (u % 4096 == 0) begin
          exp_q.push_back({1'b1, hi * 4096 + d * 128 + 32'h37});
        end else begin
          exp_q.push_back({1'b0, hi * 4096 + d * 128 + 32'h37});
          exp_q.push_back({1'b1, (u % 4096) * 1048576 + d * 32768 + d * 128 + 32'h13});
        end
      end
      return;
    end
    case (k)
      0: w = opc + d * 128 + f * 4096 + a * 32768 + b * 1048576 + sev;
      1, 2, 6: begin
        if (k == 1 && (f == 1 || f == 5))
          w = opc + d * 128 + f * 4096 + a * 32768 + (u % 32) * 1048576 + sev;
        else
          w = opc + d * 128 + f * 4096 + a * 32768 + (u % 4096) * 1048576;
        bad = (s < -2048 || s > 2047);
      end
      3: begin
        w = opc + (u % 32) * 128 + f * 4096 + a * 32768 + b * 1048576 + ((u / 32) % 128) * 33554432;
        bad = (s < -2048 || s > 2047);
      end
      4: begin
        w = opc + ((u / 2) % 16) * 256 + ((u / 2048) % 2) * 128 + f * 4096 + a * 32768
            + b * 1048576 + ((u / 32) % 64) * 33554432 + ((u / 4096) % 2) * 32'h80000000;
        bad = (s < -4096 || s > 4095 || (u % 2) != 0);
      end
      5: begin
        w = opc + d * 128 + ((u / 4096) % 256) * 4096 + ((u / 2048) % 2) * 1048576
            + ((u / 2) % 1024) * 2097152 + ((u / 1048576) % 2) * 32'h80000000;
        bad = (s < -1048576 || s > 1048575 || (u % 2) != 0);
      end
      default: begin
        w = opc + d * 128 + (u / 4096) * 4096;
        bad = ((u % 4096) != 0);
      end
    endcase
`ifdef INSTR_ENC_IMM_CHECK_EN
    if (bad) begin
      exp_err++;
      return;
    end
`endif
    exp_q.push_back({1'b1, w});
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic do_req(input logic [3:0] kind, input logic [2:0] f3, input logic alt,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input bit use_model, output int acc_cycle);
    req_kind = kind; req_funct3 = f3; req_alt = alt;
    req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
    req_valid = 1'b1;
    acc_cycle = -1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (req_ready) begin
        if (use_model) model_req(kind, f3, alt, rd, rs1, rs2, imm);
        acc_cycle = cycle;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (rand_ready) instr_ready = 1'($urandom_range(0, 1));
        return;
      end
      @(posedge clk); #1;
      if (rand_ready) instr_ready = 1'($urandom_range(0, 1));
    end
    n_checks++;
    $display("FAIL req_accept_timeout: req_ready stayed 0 for 200 cycles, required 1");
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [32:0] held;
    logic [32:0] e;
    bit hold;
    hold = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 0;
        continue;
      end
      if (err) seen_err++;
      if (hold && instr_valid) check("hold_stable", {instr_last, instr}, held);
      hold = 0;
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_word: got 0x%09h, required no word", {instr_last, instr});
        end else begin
          e = exp_q.pop_front();
          check("word", {instr_last, instr}, e);
        end
      end else if (instr_valid) begin
        hold = 1;
        held = {instr_last, instr};
      end
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [3:0]  kind;
    logic [2:0]  f3;
    logic        alt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    int          n;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;

  vec_t vecs[17];

  initial begin
    int acc;
    int accs[5];
    logic [3:0]  k;
    logic [31:0] imm;
    logic [31:0] edge_imm[12];

    vecs[0]  = '{4'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0,        1, 32'h002081B3, 32'h0};
    vecs[1]  = '{4'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0,        1, 32'h402081B3, 32'h0};
    vecs[2]  = '{4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5,        1, 32'h00500093, 32'h0};
    vecs[3]  = '{4'd2, 3'd2, 1'b0, 5'd2, 5'd1, 5'd0, 32'd4,        1, 32'h0040A103, 32'h0};
    vecs[4]  = '{4'd3, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8,        1, 32'h0020A423, 32'h0};
    vecs[5]  = '{4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8,        1, 32'h00208463, 32'h0};
    vecs[6]  = '{4'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h800,      1, 32'h001000EF, 32'h0};
    vecs[7]  = '{4'd6, 3'd0, 1'b0, 5'd0, 5'd1, 5'd0, 32'd0,        1, 32'h00008067, 32'h0};
    vecs[8]  = '{4'd7, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1, 32'h123452B7, 32'h0};
    vecs[9]  = '{4'd8, 3'd0, 1'b0, 5'd3, 5'd0, 5'd0, 32'h1000,     1, 32'h00001197, 32'h0};
    vecs[10] = '{4'd1, 3'd5, 1'b1, 5'd1, 5'd1, 5'd0, 32'd3,        1, 32'h4030D093, 32'h0};
    vecs[11] = '{4'd9, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF, 1, 32'hFFF00293, 32'h0};
    vecs[12] = '{4'd9, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1000,     1, 32'h000012B7, 32'h0};
    vecs[13] = '{4'd9, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h800,      2, 32'h000012B7, 32'h80028293};
    vecs[14] = '{4'd9, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345678, 2, 32'h123452B7, 32'h67828293};
    vecs[15] = '{4'd4, 3'd1, 1'b0, 5'd0, 5'd1, 5'd0, 32'hFFFFFFFC, 1, 32'hFE009EE3, 32'h0};
    vecs[16] = '{4'd5, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFF8, 1, 32'hFF9FF06F, 32'h0};

    edge_imm = '{32'hFFFFF800, 32'h000007FF, 32'h00000800, 32'hFFFFF7FF,
                 32'h00000FFE, 32'hFFFFF000, 32'h00001000, 32'h000FFFFE,
                 32'hFFF00000, 32'h00100000, 32'h00000001, 32'h00000000};

    rst_n = 1'b0;
    req_valid = 1'b0; req_kind = '0; req_funct3 = '0; req_alt = 1'b0;
    req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0;
    instr_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_instr_valid", 33'(instr_valid), 33'd0);
    check("rst_instr",       33'(instr),       33'd0);
    check("rst_instr_last",  33'(instr_last),  33'd0);
    check("rst_err",         33'(err),         33'd0);
    check("rst_req_ready",   33'(req_ready),   33'd1);
    check("rst_state",       33'(dbg_state),   33'(ST_IDLE));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Vector table, consumer always ready
    instr_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      if (vecs[i].n == 1) begin
        exp_q.push_back({1'b1, vecs[i].w0});
      end else begin
        exp_q.push_back({1'b0, vecs[i].w0});
        exp_q.push_back({1'b1, vecs[i].w1});
      end
      do_req(vecs[i].kind, vecs[i].f3, vecs[i].alt, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
             vecs[i].imm, 1'b0, acc);
    end
    idle(4);

    // One-cycle latency with a stalled consumer
    instr_ready = 1'b0;
    do_req(4'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, acc);
    @(negedge clk);
    check("lat_valid",     33'(instr_valid), 33'd1);
    check("lat_word",      {instr_last, instr}, {1'b1, 32'h002081B3});
    check("lat_req_ready", 33'(req_ready), 33'd0);
    @(posedge clk); #1;
    instr_ready = 1'b1;
    idle(2);

    // Two-word LI held under backpressure
    instr_ready = 1'b0;
    do_req(4'd9, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345678, 1'b1, acc);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("li_stall_word",  {instr_last, instr}, {1'b0, 32'h123452B7});
      check("li_stall_ready", 33'(req_ready), 33'd0);
    end
    check("li_stall_state", 33'(dbg_state), 33'(ST_EMIT2));
    @(posedge clk); #1;
    instr_ready = 1'b1;
    @(negedge clk);
    check("li_first_ready", 33'(req_ready), 33'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("li_second_word", {instr_last, instr}, {1'b1, 32'h67828293});
    check("li_back_idle",   33'(dbg_state), 33'(ST_IDLE));
    idle(2);

    // Illegal kind: err pulse, no word, next request normal
    do_req(4'd15, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0, 1'b1, acc);
    @(negedge clk);
    check("illegal_err",   33'(err), 33'd1);
    check("illegal_valid", 33'(instr_valid), 33'd0);
    @(posedge clk); #1;
    do_req(4'd0, 3'd7, 1'b0, 5'd9, 5'd10, 5'd11, 32'd0, 1'b1, acc);
    @(negedge clk);
    check("after_illegal_err",   33'(err), 33'd0);
    check("after_illegal_valid", 33'(instr_valid), 33'd1);
    @(posedge clk); #1;
    idle(2);

    // Back-to-back single-word throughput
    for (int i = 0; i < 5; i++)
      do_req(4'd1, 3'($urandom_range(0, 7)), 1'b0, 5'($urandom_range(0, 31)),
             5'($urandom_range(0, 31)), 5'd0, 32'($urandom_range(0, 2047)), 1'b1, accs[i]);
    for (int i = 1; i < 5; i++) check("throughput_gap", 33'(accs[i] - accs[i-1]), 33'd1);
    idle(3);

    // Odd branch offset
    do_req(4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd7, 1'b1, acc);
    @(negedge clk);
`ifdef INSTR_ENC_IMM_CHECK_EN
    check("odd_branch_err",   33'(err), 33'd1);
    check("odd_branch_valid", 33'(instr_valid), 33'd0);
`else
    check("odd_branch_valid", 33'(instr_valid), 33'd1);
    check("odd_branch_word",  {instr_last, instr}, {1'b1, 32'h00208363});
`endif
    @(posedge clk); #1;
    idle(2);

    // Randomized requests with random backpressure
    rand_ready = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 15) < 14) k = 4'($urandom_range(0, 9));
      else k = 4'($urandom_range(10, 15));
      case ($urandom_range(0, 3))
        0: imm = $urandom;
        1: imm = $urandom_range(0, 8191) - 4096;
        2: imm = $urandom & 32'hFFFFF000;
        default: imm = edge_imm[$urandom_range(0, 11)];
      endcase
      do_req(k, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
             5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), imm, 1'b1, acc);
    end
    rand_ready = 0;
    instr_ready = 1'b1;
    idle(10);

    // Reset while the second LI word is pending
    instr_ready = 1'b0;
    do_req(4'd9, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345678, 1'b1, acc);
    @(negedge clk);
    check("emit2_entered", 33'(dbg_state), 33'(ST_EMIT2));
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 33'(instr_valid), 33'd0);
    check("async_rst_state", 33'(dbg_state), 33'(ST_IDLE));
    exp_q.delete();
    idle(2);
    rst_n = 1'b1;
    instr_ready = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 33'(req_ready), 33'd1);
    repeat (5) @(negedge clk);
    check("post_rst_no_word", 33'(instr_valid), 33'd0);

    // Final accounting
    check("exp_q_drained", 33'(exp_q.size()), 33'd0);
    check("err_count", 33'(seen_err), 33'(exp_err));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
